// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC source select and
// the fixed-priority encoder that picks it.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_REDIRECT = 3'd0,
    SEL_HOLD     = 3'd1,
    SEL_RET      = 3'd2,
    SEL_CALL     = 3'd3,
    SEL_JUMP     = 3'd4,
    SEL_INC      = 3'd5
  } pc_sel_e;

  function automatic pc_sel_e pc_select(input logic redirect_valid,
                                        input logic stall,
                                        input logic ret,
                                        input logic call,
                                        input logic jump);
    pc_sel_e sel;
    if (redirect_valid) begin
      sel = SEL_REDIRECT;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (jump) begin
      sel = SEL_JUMP;
    end else begin
      sel = SEL_INC;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry and sets a sticky overflow flag; pops always return newest-first.
module pc_ras #(
  parameter int ADDR_W    = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_top;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  // ptr_q is the next free slot; the newest entry sits one below it
  assign ptr_top = ptr_q - PTR_W'(1);

  // Next-state for stack storage, pointer, count and sticky overflow
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop && (cnt_q != CNT_W'(0))) begin
      ptr_d = ptr_top;
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Stack state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign top      = mem_q[ptr_top];
  assign empty    = (cnt_q == CNT_W'(0));
  assign full     = (cnt_q == CNT_MAX);
  assign overflow = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: selects the next PC from redirect, hold, return,
// call, jump or increment, with a return-address stack for call/return.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc_current,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ret_underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              underflow_q, underflow_d;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push, ras_pop;
  pc_sel_e           sel;

  assign sel      = pc_select(redirect_valid, stall, ret, call, jump);
  assign pc_plus1 = pc_q + ADDR_W'(1);

  // Only the winning source touches the stack; a ret on an empty stack pops nothing
  assign ras_push = (sel == SEL_CALL);
  assign ras_pop  = (sel == SEL_RET) && !ras_empty;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

  // Next-PC mux and underflow pulse generation
  always_comb begin
    pc_d        = pc_plus1;
    underflow_d = 1'b0;
    case (sel)
      SEL_REDIRECT: pc_d = redirect_target;
      SEL_HOLD:     pc_d = pc_q;
      SEL_RET: begin
        if (ras_empty) begin
          pc_d        = pc_plus1;
          underflow_d = 1'b1;
        end else begin
          pc_d        = ras_top;
          underflow_d = 1'b0;
        end
      end
      SEL_CALL:     pc_d = target;
      SEL_JUMP:     pc_d = target;
      SEL_INC:      pc_d = pc_plus1;
      default:      pc_d = pc_plus1;
    endcase
  end

  // PC and underflow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VEC;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      underflow_q <= underflow_d;
    end
  end

  assign pc_current    = pc_q;
  assign ret_underflow = underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: hand-computed PC/flag sequences checked with
// immediate assertions one time unit after each rising edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, jump, call, ret;
  logic [11:0] redirect_target, target;
  logic [11:0] pc_current, pc_plus1;
  logic        ras_empty, ras_full, ras_overflow, ret_underflow;

  int n_vec = 0;
  int n_err = 0;

  pc_unit #(.ADDR_W(12), .RAS_DEPTH(4), .RESET_VEC(12'h000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .jump            (jump),
    .call            (call),
    .ret             (ret),
    .target          (target),
    .pc_current      (pc_current),
    .pc_plus1        (pc_plus1),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_overflow    (ras_overflow),
    .ret_underflow   (ret_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk_pc(input string tag, input logic [11:0] exp);
    n_vec++;
    assert (pc_current === exp) else begin
      n_err++;
      $error("FAIL %s: pc_current observed %h expected %h", tag, pc_current, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one cycle of control inputs, then sample after the edge
  task automatic step(input logic rv, input logic [11:0] rt, input logic st,
                      input logic c, input logic r, input logic j,
                      input logic [11:0] t);
    redirect_valid  = rv;
    redirect_target = rt;
    stall           = st;
    call            = c;
    ret             = r;
    jump            = j;
    target          = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    redirect_target = 12'h000; target = 12'h000;
    #2;
    chk_pc("reset_pc", 12'h000);
    n_vec++;
    assert (pc_plus1 === 12'h001) else begin
      n_err++;
      $error("FAIL reset_plus1: observed %h expected %h", pc_plus1, 12'h001);
    end
    chk_bit("reset_empty", ras_empty, 1'b1);
    chk_bit("reset_full", ras_full, 1'b0);
    chk_bit("reset_ovf", ras_overflow, 1'b0);
    chk_bit("reset_uf", ret_underflow, 1'b0);
    #10 reset = 1'b0;

    // Idle increments
    idle(); chk_pc("inc1", 12'h001);
    idle(); chk_pc("inc2", 12'h002);
    idle(); chk_pc("inc3", 12'h003);
    chk_bit("inc_empty", ras_empty, 1'b1);

    // Single call / return
    step(1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); chk_pc("redir010", 12'h010);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h100); chk_pc("call100", 12'h100);
    chk_bit("call_nonempty", ras_empty, 1'b0);
    idle(); chk_pc("sub101", 12'h101);
    idle(); chk_pc("sub102", 12'h102);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("ret011", 12'h011);
    chk_bit("ret_empty", ras_empty, 1'b1);

    // Nested calls past capacity: pushes 012,201,301,401,501
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h200); chk_pc("ncall1", 12'h200);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h300); chk_pc("ncall2", 12'h300);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h400); chk_pc("ncall3", 12'h400);
    chk_bit("ncall3_full", ras_full, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h500); chk_pc("ncall4", 12'h500);
    chk_bit("ncall4_full", ras_full, 1'b1);
    chk_bit("ncall4_ovf", ras_overflow, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h600); chk_pc("ncall5", 12'h600);
    chk_bit("ncall5_full", ras_full, 1'b1);
    chk_bit("ncall5_ovf", ras_overflow, 1'b1);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("nret1", 12'h501);
    chk_bit("nret1_full", ras_full, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("nret2", 12'h401);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("nret3", 12'h301);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("nret4", 12'h201);
    chk_bit("nret4_empty", ras_empty, 1'b1);
    chk_bit("nret4_uf", ret_underflow, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("nret5", 12'h202);
    chk_bit("nret5_uf", ret_underflow, 1'b1);
    idle(); chk_pc("after_uf", 12'h203);
    chk_bit("uf_pulse_end", ret_underflow, 1'b0);
    chk_bit("ovf_sticky", ras_overflow, 1'b1);

    // Stall blocks call; redirect overrides stall
    step(1'b1, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); chk_pc("redir020", 12'h020);
    step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h200); chk_pc("stall1", 12'h020);
    step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h200); chk_pc("stall2", 12'h020);
    chk_bit("stall_empty", ras_empty, 1'b1);
    step(1'b1, 12'h3F0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h200); chk_pc("redir_stall", 12'h3F0);
    chk_bit("redir_stall_empty", ras_empty, 1'b1);

    // call+ret+jump together: only the ret happens (stack holds 041, 055)
    step(1'b1, 12'h040, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); chk_pc("redir040", 12'h040);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h054); chk_pc("call054", 12'h054);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h080); chk_pc("call080", 12'h080);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b1, 12'h700); chk_pc("conflict", 12'h055);
    chk_bit("conflict_nonempty", ras_empty, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("conflict_ret", 12'h041);
    chk_bit("conflict_empty", ras_empty, 1'b1);

    // Plain jump leaves the stack alone
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0A0); chk_pc("jump0A0", 12'h0A0);
    chk_bit("jump_empty", ras_empty, 1'b1);

    // Wrap at all-ones, and a call there pushes 0
    step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); chk_pc("redirFFF", 12'hFFF);
    n_vec++;
    assert (pc_plus1 === 12'h000) else begin
      n_err++;
      $error("FAIL wrap_plus1: observed %h expected %h", pc_plus1, 12'h000);
    end
    idle(); chk_pc("wrap", 12'h000);
    step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); chk_pc("redirFFF2", 12'hFFF);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123); chk_pc("callFFF", 12'h123);
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("retzero", 12'h000);

    // Underflow pulse, then async reset between edges
    step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000); chk_pc("uf2", 12'h001);
    chk_bit("uf2_flag", ret_underflow, 1'b1);
    ret = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_pc("async_pc", 12'h000);
    chk_bit("async_uf", ret_underflow, 1'b0);
    chk_bit("async_ovf", ras_overflow, 1'b0);
    chk_bit("async_empty", ras_empty, 1'b1);
    chk_bit("async_full", ras_full, 1'b0);
    #3 reset = 1'b0;
    idle(); chk_pc("post_reset", 12'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
